mux16to1_reg: RTL and testbench

- 16-input, WIDTH-bit word multiplexer for the register bank read path. One of sixteen register outputs (q0..q15) is selected by a 4-bit index.
- Primary output `out` is purely combinational, for same-cycle register reads.
- A registered copy (`out_q`, with its captured index `sel_q`) is provided for pipelined read ports, using the single system clock and synchronous reset.

---
 rtl/mux16to1_reg.sv | 80 ++++++++
 tb/tb_mux16to1_reg.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux16to1_reg.sv
// 16:1 word multiplexer for the register bank read path.
// `out` is the same-cycle combinational read; `out_q`/`sel_q` are a
// registered copy for pipelined read ports.
module mux16to1_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       select,
    input  logic [WIDTH-1:0] q0,
    input  logic [WIDTH-1:0] q1,
    input  logic [WIDTH-1:0] q2,
    input  logic [WIDTH-1:0] q3,
    input  logic [WIDTH-1:0] q4,
    input  logic [WIDTH-1:0] q5,
    input  logic [WIDTH-1:0] q6,
    input  logic [WIDTH-1:0] q7,
    input  logic [WIDTH-1:0] q8,
    input  logic [WIDTH-1:0] q9,
    input  logic [WIDTH-1:0] q10,
    input  logic [WIDTH-1:0] q11,
    input  logic [WIDTH-1:0] q12,
    input  logic [WIDTH-1:0] q13,
    input  logic [WIDTH-1:0] q14,
    input  logic [WIDTH-1:0] q15,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [3:0]       sel_q
);

    logic [WIDTH-1:0] out_d;
    logic [3:0]       sel_d;

    // Full 16-way decode; an unresolvable select falls to the default and reads zero.
    always_comb begin
        out = '0;
        case (select)
            4'h0:    out = q0;
            4'h1:    out = q1;
            4'h2:    out = q2;
            4'h3:    out = q3;
            4'h4:    out = q4;
            4'h5:    out = q5;
            4'h6:    out = q6;
            4'h7:    out = q7;
            4'h8:    out = q8;
            4'h9:    out = q9;
            4'hA:    out = q10;
            4'hB:    out = q11;
            4'hC:    out = q12;
            4'hD:    out = q13;
            4'hE:    out = q14;
            4'hF:    out = q15;
            default: out = '0;
        endcase
    end

    // Next state for the registered copy: capture on en, otherwise hold.
    always_comb begin
        out_d = out_q;
        sel_d = sel_q;
        if (en) begin
            out_d = out;
            sel_d = select;
        end
    end

    // Registered read port; synchronous reset wins over en.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            sel_q <= '0;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: tb/tb_mux16to1_reg.sv
// Self-checking bench for mux16to1_reg: table-driven combinational sweep
// plus scoreboarded multi-cycle sequences for the registered port.
module tb_mux16to1_reg;

    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [3:0]       sel;
        logic [WIDTH-1:0] exp;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [3:0]       sel;
    } reg_exp_t;

    logic             clk;
    logic             reset;
    logic             en;
    logic [3:0]       select;
    logic [WIDTH-1:0] q [16];
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [3:0]       sel_q;

    int unsigned n_cmp;
    int unsigned n_err;

    vec_t     vecs [16];
    reg_exp_t sb [$];
    reg_exp_t exp_reg;

    mux16to1_reg #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .select (select),
        .q0     (q[0]),
        .q1     (q[1]),
        .q2     (q[2]),
        .q3     (q[3]),
        .q4     (q[4]),
        .q5     (q[5]),
        .q6     (q[6]),
        .q7     (q[7]),
        .q8     (q[8]),
        .q9     (q[9]),
        .q10    (q[10]),
        .q11    (q[11]),
        .q12    (q[12]),
        .q13    (q[13]),
        .q14    (q[14]),
        .q15    (q[15]),
        .out    (out),
        .out_q  (out_q),
        .sel_q  (sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Drive one cycle at the falling edge, check the combinational read,
    // then pop and check the registered expectation after the rising edge.
    task automatic drive_cycle(input logic r, input logic e, input logic [3:0] s,
                               input logic [WIDTH-1:0] exp_out);
        reg_exp_t got;
        @(negedge clk);
        reset  = r;
        en     = e;
        select = s;
        if (r) begin
            exp_reg.data = '0;
            exp_reg.sel  = '0;
        end else if (e) begin
            exp_reg.data = exp_out;
            exp_reg.sel  = s;
        end
        sb.push_back(exp_reg);
        #1;
        check("comb_out", out, exp_out);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: queue empty, got none, expected one entry");
        end else begin
            got = sb.pop_front();
            check("out_q", out_q, got.data);
            check("sel_q", {28'd0, sel_q}, {28'd0, got.sel});
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        en     = 1'b0;
        select = 4'd0;
        for (int i = 0; i < 11; i++) q[i] = WIDTH'(i);
        q[11] = 32'd20;
        q[12] = 32'd30;
        q[13] = 32'd40;
        q[14] = 32'd50;
        q[15] = 32'd60;

        for (int i = 0; i < 11; i++) begin
            vecs[i].sel = 4'(i);
            vecs[i].exp = WIDTH'(i);
        end
        vecs[11] = '{sel: 4'd11, exp: 32'd20};
        vecs[12] = '{sel: 4'd12, exp: 32'd30};
        vecs[13] = '{sel: 4'd13, exp: 32'd40};
        vecs[14] = '{sel: 4'd14, exp: 32'd50};
        vecs[15] = '{sel: 4'd15, exp: 32'd60};

        // Combinational sweep, one select value every 5 ns.
        for (int i = 0; i < 16; i++) begin
            select = vecs[i].sel;
            #1;
            check($sformatf("sweep_sel%0d", i), out, vecs[i].exp);
            #4;
        end

        // Data tracking on the selected input only.
        select = 4'd7;
        #1;
        check("track_q7_before", out, 32'd7);
        q[7] = 32'hDEADBEEF;
        #1;
        check("track_q7_change", out, 32'hDEADBEEF);
        q[6] = 32'hFFFFFFFF;
        #1;
        check("track_q6_ignored", out, 32'hDEADBEEF);

        // Reset with en=1: registers clear, out keeps tracking select.
        exp_reg.data = '0;
        exp_reg.sel  = '0;
        drive_cycle(1'b1, 1'b1, 4'd5, 32'd5);
        check("reset_out_after_edge", out, 32'd5);

        // Capture then hold.
        drive_cycle(1'b0, 1'b1, 4'd12, 32'd30);
        check("capture_out_q", out_q, 32'd30);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 4'd3, 32'd3);
        check("hold_out_q", out_q, 32'd30);
        check("hold_sel_q", {28'd0, sel_q}, 32'd12);

        // Reset priority over en.
        drive_cycle(1'b1, 1'b1, 4'd15, 32'd60);
        check("prio_out_q", out_q, 32'd0);

        // After reset, no capture until en is high.
        drive_cycle(1'b0, 1'b0, 4'd9, 32'd9);
        drive_cycle(1'b0, 1'b1, 4'd9, 32'd9);

        // Extremes at both ends of the index range.
        q[0]  = 32'hFFFFFFFF;
        q[15] = 32'h80000001;
        drive_cycle(1'b0, 1'b1, 4'd0, 32'hFFFFFFFF);
        drive_cycle(1'b0, 1'b1, 4'hF, 32'h80000001);
        check("ext_out_q_15", out_q, 32'h80000001);

        // Select and data change together.
        @(negedge clk);
        select = 4'd10;
        q[10]  = 32'h12345678;
        #1;
        check("simul_change", out, 32'h12345678);

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
